// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encoding and default frame timing constants
// used by both the RX and TX control paths.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    // One-hot RX sequencer state
    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } rx_state_e;

    // Width of a counter that must reach data_bits inclusive
    function automatic int bit_count_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

endpackage

// File: rtl/uart_control_receiver_if.sv
// RX control bundle: baud tick, serial line and FIFO status in, shift register /
// FIFO strobes and error pulses out. The receiver FSM uses the master side.
interface uart_control_receiver_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);
    localparam int BC_W = bit_count_width(DATA_BITS);

    logic            sample_tick;
    logic            serial_data_in;
    logic            full;
    logic            clear;
    logic            shift;
    logic            write;
    logic [BC_W-1:0] bit_count;
    logic            busy;
    logic            error_parity;
    logic            error_frame;
    logic            error_overrun;

    modport master (
        input  sample_tick, serial_data_in, full,
        output clear, shift, write, bit_count, busy,
               error_parity, error_frame, error_overrun
    );

    modport slave (
        output sample_tick, serial_data_in, full,
        input  clear, shift, write, bit_count, busy,
               error_parity, error_frame, error_overrun
    );

endinterface

// File: rtl/uart_rx_sample_counter.sv
// Oversample tick counter. Counts sample_tick pulses within a bit period and
// flags the middle and last tick of the period; a synchronous clear restarts it.
module uart_rx_sample_counter
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic clr,
    output logic mid_bit,
    output logic full_bit
);
    localparam int CW = $clog2(OVERSAMPLE);

    logic [CW-1:0] cnt_q;

    // Clear wins over a coincident tick so the caller can restart on a tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  cnt_q <= '0;
        else if (clr)  cnt_q <= '0;
        else if (tick) cnt_q <= cnt_q + CW'(1);
    end

    assign mid_bit  = (cnt_q == CW'(OVERSAMPLE / 2 - 1));
    assign full_bit = (cnt_q == CW'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_control_receiver.sv
// RX sequencing FSM: validates the start bit at its centre, then strobes the
// external shift register once per data bit at mid-bit, checks parity and the
// stop bit, and either writes the FIFO or reports exactly one error.
module uart_control_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input logic                     clk,
    input logic                     reset_n,
    uart_control_receiver_if.master rx
);
    localparam int BC_W = bit_count_width(DATA_BITS);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    rx_state_e       state_q, state_d;
    logic [BC_W-1:0] bit_count_q, bit_count_d;
    logic            acc_q, acc_d;
    logic            perr_flag_q, perr_flag_d;
    logic            clear_q, clear_d;
    logic            shift_q, shift_d;
    logic            write_q, write_d;
    logic            err_par_q, err_par_d;
    logic            err_frm_q, err_frm_d;
    logic            err_ovr_q, err_ovr_d;

    logic            tick, line;
    logic            cnt_clr, mid_bit, full_bit;

    assign tick = rx.sample_tick;
    assign line = rx.serial_data_in;

    // Counter is held at zero in IDLE so START counts from the falling-edge tick;
    // DATA/PARITY/STOP are timed a full bit after each mid-bit sample
    uart_rx_sample_counter #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sample_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .clr      (cnt_clr),
        .mid_bit  (mid_bit),
        .full_bit (full_bit)
    );

    // Next-state and pulse decode; nothing moves except on a sample tick
    always_comb begin
        state_d     = state_q;
        bit_count_d = bit_count_q;
        acc_d       = acc_q;
        perr_flag_d = perr_flag_q;
        clear_d     = 1'b0;
        shift_d     = 1'b0;
        write_d     = 1'b0;
        err_par_d   = 1'b0;
        err_frm_d   = 1'b0;
        err_ovr_d   = 1'b0;
        cnt_clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (tick && !line) begin
                    state_d     = START;
                    clear_d     = 1'b1;
                    bit_count_d = '0;
                end
            end
            START: begin
                if (tick && mid_bit) begin
                    if (line) begin
                        // Glitch shorter than half a bit: not a real start bit
                        state_d = IDLE;
                    end else begin
                        cnt_clr     = 1'b1;
                        acc_d       = 1'b0;
                        perr_flag_d = 1'b0;
                        state_d     = DATA;
                    end
                end
            end
            DATA: begin
                if (tick && full_bit) begin
                    cnt_clr     = 1'b1;
                    shift_d     = 1'b1;
                    acc_d       = acc_q ^ line;
                    bit_count_d = bit_count_q + BC_W'(1);
                    if (bit_count_q == BC_LAST)
                        state_d = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick && full_bit) begin
                    cnt_clr     = 1'b1;
                    perr_flag_d = acc_q ^ line ^ PARITY_ODD;
                    state_d     = STOP;
                end
            end
            STOP: begin
                // Resolve at mid stop bit so the next falling edge can be caught
                if (tick && full_bit) begin
                    if (!line)            err_frm_d = 1'b1;
                    else if (perr_flag_q) err_par_d = 1'b1;
                    else if (rx.full)     err_ovr_d = 1'b1;
                    else                  write_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, frame bookkeeping and registered output pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_count_q <= '0;
            acc_q       <= 1'b0;
            perr_flag_q <= 1'b0;
            clear_q     <= 1'b0;
            shift_q     <= 1'b0;
            write_q     <= 1'b0;
            err_par_q   <= 1'b0;
            err_frm_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
            acc_q       <= acc_d;
            perr_flag_q <= perr_flag_d;
            clear_q     <= clear_d;
            shift_q     <= shift_d;
            write_q     <= write_d;
            err_par_q   <= err_par_d;
            err_frm_q   <= err_frm_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    assign rx.clear         = clear_q;
    assign rx.shift         = shift_q;
    assign rx.write         = write_q;
    assign rx.bit_count     = bit_count_q;
    assign rx.busy          = (state_q != IDLE);
    assign rx.error_parity  = err_par_q;
    assign rx.error_frame   = err_frm_q;
    assign rx.error_overrun = err_ovr_q;

endmodule

// File: tb/tb_uart_control_receiver.sv
// Bench for uart_control_receiver: frame table driven through a scoreboard of
// expected end-of-frame results, plus hand sequences for false start, reset
// mid-frame and a stuck-low line. A second DUT with odd parity shares the line.
module tb_uart_control_receiver;
    import uart_pkg::*;

    localparam int DB = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sample_tick = 1'b0;
    logic line = 1'b1;
    logic full = 1'b0;
    logic [1:0] div = 2'd0;
    int   tick_num = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int start_tick = 0;
    int f_clear = 0;
    int f_shift = 0;
    int n_done  = 0;
    int o_write = 0;
    logic [3:0] sb_q[$];

    typedef struct {
        logic [7:0] d;
        logic       pb;
        logic       sb;
        logic       fm;
        logic       fs;
        logic [3:0] res;   // {write, parity, frame, overrun}
        int         odd_w;
    } vec_t;
    vec_t vecs[10];

    uart_control_receiver_if #(.DATA_BITS(DB)) rif ();
    uart_control_receiver_if #(.DATA_BITS(DB)) oif ();

    assign rif.sample_tick    = sample_tick;
    assign rif.serial_data_in = line;
    assign rif.full           = full;
    assign oif.sample_tick    = sample_tick;
    assign oif.serial_data_in = line;
    assign oif.full           = 1'b0;

    uart_control_receiver #(.DATA_BITS(DB), .OVERSAMPLE(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
        dut (.clk(clk), .reset_n(reset_n), .rx(rif));
    uart_control_receiver #(.DATA_BITS(DB), .OVERSAMPLE(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b1))
        dut_odd (.clk(clk), .reset_n(reset_n), .rx(oif));

    always #5 clk = ~clk;

    // One tick every four clocks, changed on the falling edge
    always @(negedge clk) begin
        div         <= div + 2'd1;
        sample_tick <= (div == 2'd3);
    end

    always @(posedge clk) if (sample_tick) tick_num <= tick_num + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pulse timing relative to the falling-edge tick, scoreboard pop at frame end
    always @(negedge clk) begin
        int rel;
        logic [3:0] exp_res;
        if (reset_n) begin
            rel = tick_num - 1 - start_tick;
            if (rif.clear) begin
                if (f_clear == 0) check("clear_tick", rel, 0);
                f_clear++;
                f_shift = 0;
            end
            if (rif.shift) begin
                check("shift_tick", rel, 24 + 16 * f_shift);
                f_shift++;
            end
            if (rif.write | rif.error_parity | rif.error_frame | rif.error_overrun) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %b expected none",
                             {rif.write, rif.error_parity, rif.error_frame, rif.error_overrun});
                end else begin
                    exp_res = sb_q.pop_front();
                    check("result", int'({rif.write, rif.error_parity, rif.error_frame, rif.error_overrun}),
                          int'(exp_res));
                    check("bit_count_end", int'(rif.bit_count), DB);
                    check("shift_count", f_shift, DB);
                end
                n_done++;
            end
            if (oif.write) o_write++;
        end
    end

    task automatic wait_tick();
        @(posedge clk);
        while (!sample_tick) @(posedge clk);
    endtask

    // Hold the line for n ticks; entered and left just after a tick edge
    task automatic drive_bit(input logic v, input int n);
        line = v;
        repeat (n) wait_tick();
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb,
                              input logic fm, input logic fs);
        start_tick = tick_num;
        f_clear    = 0;
        full       = fm;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
        drive_bit(pb, 16);
        full = fs;
        drive_bit(sb, 16);
        full = 1'b0;
        drive_bit(1'b1, 4);
    endtask

    function automatic int all_outputs();
        return int'({rif.clear, rif.shift, rif.write, rif.error_parity, rif.error_frame,
                     rif.error_overrun, rif.busy, rif.bit_count});
    endfunction

    initial begin
        int exp_done;
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 0};
        vecs[3] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 0};
        vecs[4] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 0};
        vecs[5] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1000, 0};
        vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 0};
        vecs[7] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 0};
        vecs[8] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 1};
        vecs[9] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 0};

        // Reset state
        repeat (4) @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        reset_n = 1'b1;
        wait_tick();
        #1;
        drive_bit(1'b1, 4);
        check("idle_busy", int'(rif.busy), 0);

        // Frame table
        foreach (vecs[i]) begin
            exp_done = n_done + 1;
            o_write  = 0;
            sb_q.push_back(vecs[i].res);
            send_frame(vecs[i].d, vecs[i].pb, vecs[i].sb, vecs[i].fm, vecs[i].fs);
            check("frame_done", n_done, exp_done);
            check("busy_after_stop", int'(rif.busy), 0);
            check("odd_write", o_write, vecs[i].odd_w);
        end

        // False start: low for 4 ticks, back to IDLE at tick index 8
        exp_done   = n_done;
        start_tick = tick_num;
        f_clear    = 0;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 4);
        check("false_start_busy_held", int'(rif.busy), 1);
        drive_bit(1'b1, 1);
        check("false_start_busy_drop", int'(rif.busy), 0);
        check("false_start_clear", f_clear, 1);
        check("false_start_shift", f_shift, 0);
        check("false_start_no_result", n_done, exp_done);

        // Reset after three shifts abandons the frame
        start_tick = tick_num;
        f_clear    = 0;
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b1, 5);
        check("pre_reset_shifts", f_shift, 3);
        exp_done = n_done;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_reset_outputs", all_outputs(), 0);
        line = 1'b1;
        reset_n = 1'b1;
        wait_tick();
        #1;
        drive_bit(1'b1, 8);
        check("post_reset_outputs", all_outputs(), 0);
        check("post_reset_no_result", n_done, exp_done);
        sb_q.push_back(4'b1000);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        check("post_reset_frame", n_done, exp_done + 1);

        // Stuck-low line: frame error, then an immediate new start
        exp_done   = n_done + 1;
        start_tick = tick_num;
        f_clear    = 0;
        sb_q.push_back(4'b0010);
        drive_bit(1'b0, 172);
        check("stuck_low_result", n_done, exp_done);
        check("stuck_low_restart", f_clear, 2);
        check("stuck_low_busy", int'(rif.busy), 1);
        drive_bit(1'b1, 12);
        check("stuck_low_recover", int'(rif.busy), 0);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
